tiny16_io_arbiter: RTL
======================

Name: tiny16_io_arbiter

Overview:
- Shares the single 8-bit-address / 16-bit-data peripheral I/O bus between two masters.
  - M0: the tiny16 core's io port.
  - M1: a secondary requester, e.g. DMA or debug.
- Arbitrates between masters, sequences each transfer as a registered three-phase transaction, and enforces a slave timeout.
- Sits between the masters and the peripheral address decoder; both master ports follow the core's valid/ready stall protocol.

Parameters:
- TIMEOUT_BITS, 8: width of the slave-response watchdog counter.
- TIMEOUT, 200: BUSY cycles without io_ready before the transfer is aborted; legal range 1..2^TIMEOUT_BITS-1.
- FIXED_PRIORITY, 0: 0 = round-robin; 1 = M0 always wins a tie.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- m0_valid  in  1  M0 request; held until m0_ready
- m0_nwr  in  1  M0 direction: 1 = read, 0 = write
- m0_address  in  8  M0 I/O address
- m0_data_out  in  16  M0 write data
- m0_ready  out  1  one-cycle completion pulse to M0
- m0_data_in  out  16  read data to M0, valid while m0_ready=1
- m1_valid, m1_nwr, m1_address, m1_data_out, m1_ready, m1_data_in: same as M0, for master 1
- io_valid  out  1  bus request to slaves
- io_nwr  out  1  bus direction
- io_address  out  8  bus address
- io_data_out  out  16  bus write data
- io_ready  in  1  slave completion; ignored while io_valid=0
- io_data_in  in  16  slave read data, sampled with io_ready
- grant  out  2  one-hot owner of the current transaction; 00 when idle
- timeout_error  out  1  one-cycle pulse on watchdog abort
- error_master  out  1  master index of the last aborted transfer; holds until the next abort

Behaviour:
- Reset values (clk edge with reset=1):
  - state=IDLE; io_valid=0, io_nwr=1, io_address=0, io_data_out=0
  - m0_ready=m1_ready=0, m0_data_in=m1_data_in=0
  - grant=00, timeout_error=0, error_master=0
  - last_winner=1, so M0 wins the first round-robin tie.
- Reset asserted mid-transaction: transaction dropped, no ready pulse issued, all outputs return to reset values on that edge.
- States: IDLE -> BUSY -> RESP -> IDLE.
- IDLE:
  - No request: stay in IDLE.
  - Only one valid: that master wins.
  - Both valid: winner is the master other than last_winner (round-robin) or M0 (FIXED_PRIORITY=1).
  - On the arbitration edge: latch winner's nwr/address/data_out into io_*, set io_valid=1, set grant, update last_winner, clear watchdog, go BUSY.
- BUSY:
  - io_valid held high; io_* fields stable for the whole phase.
  - Watchdog increments each cycle.
  - io_ready=1: capture io_data_in (reads only; writes capture nothing and leave the data_in register unchanged), drop io_valid, go RESP.
  - Watchdog == TIMEOUT-1 with no io_ready: drop io_valid, load read data 16'hFFFF, pulse timeout_error, record error_master, go RESP.
  - io_ready arriving on the timeout cycle takes precedence: normal completion, no error.
- RESP:
  - Granted master's mN_ready=1 for exactly this cycle; mN_data_in holds the captured value (kept until the next read for that master).
  - grant held through RESP; cleared to 00 on the edge into IDLE.
  - Go IDLE. A request still asserted during RESP is the consumed one and is not re-arbitrated.
  - New arbitration starts in the cycle after RESP.
- Latency, request seen in IDLE at cycle 0:
  - io_valid high from cycle 1.
  - io_ready in cycle k gives mN_ready in cycle k+1.
  - Minimum 3 cycles (k=1) per transfer.
- Losing master stalls with its valid high; it is served in the next IDLE (starvation-free in round-robin mode).
- Masters must not change their fields while valid=1; the arbiter samples them only in IDLE.
- Watchdog saturates, never wraps.

Test Plan:
- Single read: reset, then m0_valid=1, m0_nwr=1, m0_address=8'h12; slave io_ready=1 with io_data_in=16'hBEEF in 2nd BUSY cycle -> io_address=8'h12 from cycle 1, m0_ready pulse in cycle 3, m0_data_in=16'hBEEF, grant=01 during cycles 1-3.
- Write: m1_valid=1, m1_nwr=0, m1_address=8'h40, m1_data_out=16'h1234; io_ready in 1st BUSY cycle -> io_nwr=0, io_data_out=16'h1234, m1_ready in cycle 2, m1_data_in unchanged.
- Contention, round-robin: both valid continuously, each slave answers in 1 cycle -> grant sequence 01,10,01,10, one transfer per 3 cycles. Same stimulus with FIXED_PRIORITY=1 -> M0 served every slot while m0_valid stays high.
- Timeout: TIMEOUT=4, M1 read, io_ready never asserted -> io_valid high exactly 4 cycles, timeout_error pulse with m1_ready, m1_data_in=16'hFFFF, error_master=1. Repeat with io_ready in the 4th BUSY cycle -> normal completion, no error.
- Reset mid-BUSY: assert reset during the 2nd BUSY cycle -> next edge io_valid=0, grant=00, no mN_ready pulse. Re-request after reset release -> M0 wins the tie.

Source files
------------

// File: rtl/tiny16_io_arbiter.sv
// tiny16_io_arbiter: shares the 8-bit-address / 16-bit-data peripheral I/O bus
// between the core (M0) and a secondary requester (M1). Each transfer runs
// IDLE -> BUSY -> RESP with every output registered. A watchdog aborts any
// transfer whose slave stays silent for TIMEOUT cycles.
module tiny16_io_arbiter #(
    parameter int TIMEOUT_BITS   = 8,
    parameter int TIMEOUT        = 200,
    parameter bit FIXED_PRIORITY = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    // master 0 (core)
    input  logic        m0_valid,
    input  logic        m0_nwr,
    input  logic [7:0]  m0_address,
    input  logic [15:0] m0_data_out,
    output logic        m0_ready,
    output logic [15:0] m0_data_in,
    // master 1 (DMA / debug)
    input  logic        m1_valid,
    input  logic        m1_nwr,
    input  logic [7:0]  m1_address,
    input  logic [15:0] m1_data_out,
    output logic        m1_ready,
    output logic [15:0] m1_data_in,
    // shared slave bus
    output logic        io_valid,
    output logic        io_nwr,
    output logic [7:0]  io_address,
    output logic [15:0] io_data_out,
    input  logic        io_ready,
    input  logic [15:0] io_data_in,
    // status
    output logic [1:0]  grant,
    output logic        timeout_error,
    output logic        error_master
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    // Watchdog value seen on the last permitted silent BUSY cycle.
    localparam logic [TIMEOUT_BITS-1:0] WDOG_LAST = TIMEOUT_BITS'(TIMEOUT - 1);
    localparam logic [TIMEOUT_BITS-1:0] WDOG_MAX  = '1;

    state_t                  state, state_nx;
    logic [TIMEOUT_BITS-1:0] wdog, wdog_nx;
    logic                    last_winner, last_winner_nx;
    logic                    pick;
    logic                    owner;

    logic        io_valid_nx, io_nwr_nx;
    logic [7:0]  io_address_nx;
    logic [15:0] io_data_out_nx;
    logic        m0_ready_nx, m1_ready_nx;
    logic [15:0] m0_data_in_nx, m1_data_in_nx;
    logic [1:0]  grant_nx;
    logic        timeout_error_nx, error_master_nx;

    // The one-hot grant doubles as the owner index while a transfer is open.
    assign owner = grant[1];

    // Arbitration: a lone requester wins; a tie goes to M0 in fixed mode,
    // otherwise to the master that did not win last time.
    always_comb begin
        if (m0_valid && m1_valid) begin
            pick = FIXED_PRIORITY ? 1'b0 : ~last_winner;
        end else begin
            pick = m1_valid;
        end
    end

    // Next-state and next-output logic for the three-phase transaction.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one
        // unassigned; otherwise synthesis infers a latch to hold it.
        state_nx         = state;
        wdog_nx          = wdog;
        last_winner_nx   = last_winner;
        io_valid_nx      = io_valid;
        io_nwr_nx        = io_nwr;
        io_address_nx    = io_address;
        io_data_out_nx   = io_data_out;
        m0_ready_nx      = 1'b0;
        m1_ready_nx      = 1'b0;
        m0_data_in_nx    = m0_data_in;
        m1_data_in_nx    = m1_data_in;
        grant_nx         = grant;
        timeout_error_nx = 1'b0;
        error_master_nx  = error_master;

        unique case (state)
            IDLE: begin
                if (m0_valid || m1_valid) begin
                    io_valid_nx    = 1'b1;
                    io_nwr_nx      = pick ? m1_nwr      : m0_nwr;
                    io_address_nx  = pick ? m1_address  : m0_address;
                    io_data_out_nx = pick ? m1_data_out : m0_data_out;
                    grant_nx       = pick ? 2'b10 : 2'b01;
                    last_winner_nx = pick;
                    wdog_nx        = '0;
                    state_nx       = BUSY;
                end
            end

            BUSY: begin
                if (io_ready) begin
                    // A slave answer wins even on the watchdog's last cycle.
                    io_valid_nx = 1'b0;
                    if (io_nwr) begin
                        if (owner) m1_data_in_nx = io_data_in;
                        else       m0_data_in_nx = io_data_in;
                    end
                    m0_ready_nx = ~owner;
                    m1_ready_nx = owner;
                    state_nx    = RESP;
                end else if (wdog == WDOG_LAST) begin
                    // Abort: the all-ones pattern marks the dead transfer.
                    io_valid_nx      = 1'b0;
                    if (owner) m1_data_in_nx = 16'hFFFF;
                    else       m0_data_in_nx = 16'hFFFF;
                    m0_ready_nx      = ~owner;
                    m1_ready_nx      = owner;
                    timeout_error_nx = 1'b1;
                    error_master_nx  = owner;
                    state_nx         = RESP;
                end else if (wdog != WDOG_MAX) begin
                    wdog_nx = wdog + 1'b1;
                end
            end

            RESP: begin
                // The still-asserted request here is the one just served.
                grant_nx = 2'b00;
                state_nx = IDLE;
            end

            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State, watchdog and registered outputs; synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every
        // register samples values from before the edge.
        if (reset) begin
            state         <= IDLE;
            wdog          <= '0;
            last_winner   <= 1'b1;
            io_valid      <= 1'b0;
            io_nwr        <= 1'b1;
            io_address    <= 8'h00;
            io_data_out   <= 16'h0000;
            m0_ready      <= 1'b0;
            m1_ready      <= 1'b0;
            m0_data_in    <= 16'h0000;
            m1_data_in    <= 16'h0000;
            grant         <= 2'b00;
            timeout_error <= 1'b0;
            error_master  <= 1'b0;
        end else begin
            state         <= state_nx;
            wdog          <= wdog_nx;
            last_winner   <= last_winner_nx;
            io_valid      <= io_valid_nx;
            io_nwr        <= io_nwr_nx;
            io_address    <= io_address_nx;
            io_data_out   <= io_data_out_nx;
            m0_ready      <= m0_ready_nx;
            m1_ready      <= m1_ready_nx;
            m0_data_in    <= m0_data_in_nx;
            m1_data_in    <= m1_data_in_nx;
            grant         <= grant_nx;
            timeout_error <= timeout_error_nx;
            error_master  <= error_master_nx;
        end
    end

endmodule
